// File: rtl/audio_sample_pacer.sv
// Audio sample pacer: an Avalon-MM loaded sample FIFO, drained one sample per
// timer tick into a valid/ready output slot, with status, underrun count and irq.
module audio_sample_pacer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        tick,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [LW-1:0] r_level;
    logic [2:0]    r_ctrl;
    logic [8:0]    r_thresh;
    logic          r_underrun;
    logic          r_overflow;
    logic          r_late;
    logic [15:0]   r_ucnt;
    logic [15:0]   r_readdata;
    logic [15:0]   r_sample_out;
    logic          r_sample_valid;

    logic          w_wr;
    logic          w_data_wr;
    logic          w_ctrl_wr;
    logic          w_stat_clr;
    logic          w_thr_wr;
    logic          w_ucnt_clr;
    logic          w_flush;
    logic          w_full;
    logic          w_empty;
    logic          w_low;
    logic          w_tick_en;
    logic          w_slot_free;
    logic          w_load;
    logic          w_pop;
    logic          w_underrun;
    logic          w_late;
    logic          w_push;
    logic          w_overflow;
    logic [15:0]   w_status;
    logic [15:0]   w_rd_mux;

    assign w_wr       = chipselect & ~write_n;
    assign w_data_wr  = w_wr && (address == 3'd0);
    assign w_ctrl_wr  = w_wr && (address == 3'd1);
    assign w_stat_clr = w_wr && (address == 3'd2);
    assign w_thr_wr   = w_wr && (address == 3'd4);
    assign w_ucnt_clr = w_wr && (address == 3'd5);
    assign w_flush    = w_ctrl_wr & writedata[3];

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_low   = (9'(r_level) < r_thresh);

    // A flush in the same cycle makes the tick see an empty FIFO.
    assign w_tick_en   = tick & r_ctrl[0];
    assign w_slot_free = ~r_sample_valid | sample_ready;
    assign w_load      = w_tick_en & w_slot_free;
    assign w_late      = w_tick_en & ~w_slot_free;
    assign w_pop       = w_load & ~w_flush & ~w_empty;
    assign w_underrun  = w_load & (w_flush | w_empty);
    assign w_push      = w_data_wr & (~w_full | w_pop);
    assign w_overflow  = w_data_wr & w_full & ~w_pop;

    assign w_status = {10'd0, r_late, r_overflow, w_empty, w_full, r_underrun, w_low};

    always_comb begin
        w_rd_mux = 16'h0000;
        case (address)
            3'd1:    w_rd_mux = {13'd0, r_ctrl};
            3'd2:    w_rd_mux = w_status;
            3'd3:    w_rd_mux = 16'(r_level);
            3'd4:    w_rd_mux = {7'd0, r_thresh};
            3'd5:    w_rd_mux = r_ucnt;
            default: w_rd_mux = 16'h0000;
        endcase
    end

    // Sample storage carries no reset; contents are meaningless once level is 0.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_out   <= 16'h0000;
            r_sample_valid <= 1'b0;
        end else if (w_load) begin
            r_sample_out   <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
            r_sample_valid <= 1'b1;
        end else if (sample_ready) begin
            r_sample_valid <= 1'b0;
        end
    end

    // Sticky bits: a new event in the clearing cycle wins so it is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl     <= 3'd0;
            r_thresh   <= 9'd4;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
            r_ucnt     <= 16'h0000;
            r_readdata <= 16'h0000;
        end else begin
            if (w_ctrl_wr) r_ctrl <= writedata[2:0];
            if (w_thr_wr)  r_thresh <= writedata[8:0];
            r_underrun <= (r_underrun & ~w_stat_clr) | w_underrun;
            r_overflow <= (r_overflow & ~w_stat_clr) | w_overflow;
            r_late     <= (r_late & ~w_stat_clr) | w_late;
            if (w_ucnt_clr)
                r_ucnt <= {15'd0, w_underrun};
            else if (w_underrun && (r_ucnt != 16'hFFFF))
                r_ucnt <= r_ucnt + 16'd1;
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata     = r_readdata;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign irq          = (r_ctrl[1] & w_low) | (r_ctrl[2] & r_underrun);

endmodule

// File: doc/audio_sample_pacer.md
AUDIO_SAMPLE_PACER -- requirements
Module: audio_sample_pacer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in 16-bit samples, power of two, 4..256.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port address  input  3  register word select.
REQ-005 SHALL have ports chipselect, write_n  input  1 each  Avalon-MM slave controls; a write occurs when chipselect=1 and write_n=0.
REQ-006 SHALL have port writedata  input  16  write data.
REQ-007 SHALL have port readdata  output  16  registered read data.
REQ-008 SHALL have port tick  input  1  single-cycle sample-rate pulse from the interval timer timeout.
REQ-009 SHALL have ports sample_out  output  16  and sample_valid  output  1  downstream sample and qualifier.
REQ-010 SHALL have port sample_ready  input  1  downstream accept.
REQ-011 SHALL have port irq  output  1  level interrupt.

Function
REQ-012 SHALL implement this register map: 0 DATA (write pushes sample; reads 0); 1 CONTROL[2:0] = {irq_en_underrun, irq_en_low, enable}; 2 STATUS; 3 LEVEL; 4 THRESHOLD; 5 UNDERRUN_COUNT. Other addresses read 0, and writes to them are ignored.
REQ-013 SHALL drive readdata with the selected register value one cycle after the address is presented, on every cycle, with no read side effects.
REQ-014 SHALL treat CONTROL writedata[3] as flush: it is write-1, self-clearing, and not stored. Flush empties the FIFO (level=0) and leaves sample_out/sample_valid unchanged.
REQ-015 SHALL define STATUS as follows: [0] low = level<threshold (live); [1] underrun (sticky); [2] full (live); [3] empty (live); [4] overflow (sticky); [5] late (sticky). Any write to address 2 clears all sticky bits.
REQ-016 SHALL report LEVEL as the occupancy, 0..DEPTH, zero-extended to 16 bits.
REQ-017 SHALL store THRESHOLD[8:0]. The stored value is compared unsigned against level.
REQ-018 DATA write with FIFO not full SHALL append writedata; level increments on the next edge.
REQ-019 DATA write with FIFO full and no pop in the same cycle SHALL discard the data and set overflow; level stays DEPTH.
REQ-020 DATA write and pop in the same cycle with FIFO full SHALL both take effect, leaving level=DEPTH.
REQ-021 tick with enable=0 SHALL be ignored, with no state change.
REQ-022 tick with enable=1 and sample_valid=1 and sample_ready=0 SHALL be dropped and set late; the FIFO and outputs are unchanged.
REQ-023 tick with enable=1, the output slot free (sample_valid=0 or sample_ready=1), and FIFO non-empty SHALL load the FIFO head into sample_out, pop it, and assert sample_valid on the next edge.
REQ-024 tick with enable=1, the output slot free, and FIFO empty SHALL load sample_out=0 with sample_valid=1, set underrun, and increment UNDERRUN_COUNT, which saturates at 16'hFFFF.
REQ-025 sample_valid SHALL stay 1 with sample_out stable until a cycle with sample_ready=1; it then clears on the next edge unless a REQ-023/024 reload occurs on the same edge.
REQ-026 Flush and tick in the same cycle: flush SHALL take priority and the tick SHALL be treated as against an empty FIFO (REQ-024).
REQ-027 A write to address 5 SHALL clear UNDERRUN_COUNT; if an underrun occurs in the same cycle, the count SHALL be 1.
REQ-028 irq SHALL equal (irq_en_low AND low) OR (irq_en_underrun AND underrun), derived from registered state only.
REQ-029 Clearing enable SHALL not alter a pending sample_valid handshake.

Reset
REQ-030 On reset_n=0 the block SHALL set readdata=0, sample_out=0, sample_valid=0, irq=0, CONTROL=0, level=0, THRESHOLD=4, all sticky bits=0, and UNDERRUN_COUNT=0, asynchronously.
REQ-031 Reset asserted mid-handshake SHALL drop sample_valid immediately; any FIFO contents are lost.

Verification
REQ-032 Basic pacing: write 3 samples 0x1111/0x2222/0x3333, enable=1, sample_ready=1, three ticks -> sample_out 0x1111, 0x2222, 0x3333 each valid one cycle after its tick; LEVEL reads 0.
REQ-033 Underrun: enable=1, empty FIFO, 2 ticks -> two sample_valid pulses with sample_out=0; STATUS[1]=1; UNDERRUN_COUNT=2; irq=1 with irq_en_underrun=1; write to address 2 -> irq=0.
REQ-034 Overflow/full: DEPTH=16, 17 writes -> LEVEL=16, STATUS[2]=1, STATUS[4]=1; the 17th value is never output.
REQ-035 Backpressure: sample_ready=0, 2 ticks with 2 samples queued -> first sample held, second tick sets late, LEVEL=1; raise sample_ready -> valid drops the next cycle.
REQ-036 Threshold irq: THRESHOLD=4, irq_en_low=1, LEVEL=5 -> irq=0; one tick -> LEVEL=4, irq=0; another tick -> LEVEL=3, irq=1.
REQ-037 Flush + tick in the same cycle with LEVEL=6 -> LEVEL=0, sample_out=0, underrun set.
